// File: rtl/raycast_pkg.sv
// Shared types and screen defaults for the raycaster pipeline.
// Used by the ray process elements and by column_renderer.
package raycast_pkg;

    typedef logic [7:0] color_t;
    typedef logic [9:0] height_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_COL = 2'd1,
        DRAW     = 2'd2,
        DONE     = 2'd3
    } render_state_e;

    localparam int DEFAULT_SCREEN_WIDTH  = 800;
    localparam int DEFAULT_SCREEN_HEIGHT = 600;

    // Distance darkening: halve the palette index.
    function automatic color_t shade_color(input color_t c);
        return {1'b0, c[7:1]};
    endfunction

endpackage

// File: rtl/column_span_calc.sv
// column_span_calc: on a column handshake, registers the clamped wall
// span (top/bot rows) and the wall colour. Outputs are valid one cycle
// after load. Optional macro DIST_SHADE_EN darkens short (distant) walls.
module column_span_calc
    import raycast_pkg::*;
#(
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] col_color,
    input  logic [9:0] col_height,
    output logic [7:0] wall_color,
    output logic [9:0] top,
    output logic [9:0] bot
);

    localparam height_t H_MAX = height_t'(SCREEN_HEIGHT);
`ifdef DIST_SHADE_EN
    localparam height_t SHADE_LIMIT = height_t'(SCREEN_HEIGHT / 4);
`endif

    height_t h_clamp;
    height_t top_next;
    color_t  color_next;

    // Clamp the height, centre the span (odd residual row falls to the floor) and pick the wall colour.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        h_clamp    = (col_height > H_MAX) ? H_MAX : col_height;
        top_next   = (H_MAX - h_clamp) >> 1;
        color_next = col_color;
`ifdef DIST_SHADE_EN
        if (h_clamp < SHADE_LIMIT) begin
            color_next = shade_color(col_color);
        end
`endif
    end

    // Capture the span and colour on the handshake.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wall_color <= '0;
            top        <= '0;
            bot        <= '0;
        end else if (load) begin
            wall_color <= color_next;
            top        <= top_next;
            bot        <= top_next + h_clamp;
        end
    end

endmodule

// File: rtl/column_renderer.sv
// column_renderer: consumes one {color,height} result per screen column,
// left to right, and writes ceiling / centred wall / floor pixels for that
// column to the framebuffer write port, one row per accepted write.
// Optional macro DIST_SHADE_EN (in column_span_calc) darkens distant walls.
module column_renderer
    import raycast_pkg::*;
#(
    parameter int     SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int     SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int     ADDR_W        = 19,
    parameter color_t CEIL_COLOR    = 8'h11,
    parameter color_t FLOOR_COLOR   = 8'h22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              col_valid,
    output logic              col_ready,
    input  logic [7:0]        col_color,
    input  logic [9:0]        col_height,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    input  logic              fb_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [1:0] ST_IDLE     = 2'(IDLE);
    localparam logic [1:0] ST_WAIT_COL = 2'(WAIT_COL);
    localparam logic [1:0] ST_DRAW     = 2'(DRAW);
    localparam logic [1:0] ST_DONE     = 2'(DONE);

    localparam int                XW         = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
    localparam logic [XW-1:0]     X_LAST     = XW'(SCREEN_WIDTH - 1);
    localparam height_t           Y_LAST     = height_t'(SCREEN_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_WIDTH);

    logic [1:0]    state;
    logic [XW-1:0] x;
    height_t       y;
    logic          col_accept;
    color_t        wall_color;
    height_t       span_top;
    height_t       span_bot;

    assign col_ready  = (state == ST_WAIT_COL);
    assign col_accept = col_ready && col_valid;
    assign fb_we      = (state == ST_DRAW);
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);

    column_span_calc #(
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_span (
        .clk        (clk),
        .rst        (rst),
        .load       (col_accept),
        .col_color  (col_color),
        .col_height (col_height),
        .wall_color (wall_color),
        .top        (span_top),
        .bot        (span_bot)
    );

    // Pixel colour for the current row; zero outside DRAW.
    always_comb begin
        fb_data = 8'h00;
        if (state == ST_DRAW) begin
            if (y < span_top) begin
                fb_data = CEIL_COLOR;
            end else if (y < span_bot) begin
                fb_data = wall_color;
            end else begin
                fb_data = FLOOR_COLOR;
            end
        end
    end

    // Frame sequencing plus running column/row position and framebuffer address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            x       <= '0;
            y       <= '0;
            fb_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state   <= ST_WAIT_COL;
                        x       <= '0;
                        y       <= '0;
                        fb_addr <= '0;
                    end
                end
                ST_WAIT_COL: begin
                    if (col_valid) begin
                        state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (fb_ready) begin
                        if (y == Y_LAST) begin
                            y <= '0;
                            if (x == X_LAST) begin
                                state <= ST_DONE;
                            end else begin
                                // Top row of the next column sits at address x+1.
                                x       <= x + XW'(1);
                                fb_addr <= ADDR_W'(x) + ADDR_W'(1);
                                state   <= ST_WAIT_COL;
                            end
                        end else begin
                            y       <= y + height_t'(1);
                            fb_addr <= fb_addr + ROW_STRIDE;
                        end
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    fb_addr <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
